// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, immediate-type encodings, the
// registered execute bundle and the operand-forwarding helper.
package cpu_pkg;

  // Major opcodes understood by the decode/issue stage.
  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_e;

  // Which immediate, if any, drives the B operand.
  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_U
  } imm_type_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Everything the execute stage receives alongside o_ex_valid.
  typedef struct packed {
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_en;
    logic        alu_imm;
    logic [4:0]  rd;
    logic        we;
    logic        load;
    logic        store;
    logic        illegal;
  } ex_bundle_t;

  // Youngest producer wins: memory stage over writeback over the register
  // file. x0 is hard-wired to zero even if a stage claims to write it.
  function automatic logic [31:0] fwd_operand(
    input logic [4:0]  rs,
    input logic [31:0] rf_data,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_data,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (rs == REG_ZERO)                return '0;
    else if (mem_we && (mem_rd == rs)) return mem_data;
    else if (wb_we && (wb_rd == rs))   return wb_data;
    else                               return rf_data;
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Decode-to-execute issue channel: registered operands/controls plus the
// execute stage's ready.
interface decode_issue_if;
  import cpu_pkg::*;

  logic        i_ex_ready;
  logic        o_ex_valid;
  logic [31:0] o_ex_in_a;
  logic [31:0] o_ex_in_b;
  logic [2:0]  o_ex_funct3;
  logic [6:0]  o_ex_funct7;
  logic        o_ex_alu_en;
  logic        o_ex_alu_imm;
  logic [4:0]  o_ex_rd;
  logic        o_ex_we;
  logic        o_ex_load;
  logic        o_ex_store;
  logic [31:0] o_ex_store_data;
  logic        o_ex_illegal;

  modport master (
    input  i_ex_ready,
    output o_ex_valid, o_ex_in_a, o_ex_in_b, o_ex_funct3, o_ex_funct7,
           o_ex_alu_en, o_ex_alu_imm, o_ex_rd, o_ex_we, o_ex_load,
           o_ex_store, o_ex_store_data, o_ex_illegal
  );

  modport slave (
    output i_ex_ready,
    input  o_ex_valid, o_ex_in_a, o_ex_in_b, o_ex_funct3, o_ex_funct7,
           o_ex_alu_en, o_ex_alu_imm, o_ex_rd, o_ex_we, o_ex_load,
           o_ex_store, o_ex_store_data, o_ex_illegal
  );
endinterface

// File: rtl/decode_issue_imm_gen.sv
// Immediate generator: extracts the sign-extended I/S immediates and the
// upper U immediate from a raw instruction word.
module imm_gen (
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_u
);
  assign o_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign o_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign o_imm_u = {i_inst[31:12], 12'h000};
endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes the offered instruction, forwards operands,
// detects load-use hazards and registers one instruction toward execute.
module decode_issue
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_inst,
  input  logic [31:0] i_if_pc,
  output logic        o_if_ready,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_fwd_mem_we,
  input  logic [4:0]  i_fwd_mem_rd,
  input  logic [31:0] i_fwd_mem_data,
  input  logic        i_fwd_wb_we,
  input  logic [4:0]  i_fwd_wb_rd,
  input  logic [31:0] i_fwd_wb_data,
  decode_issue_if.master ex
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_u;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  imm_type_e   w_imm_type;
  ex_bundle_t  w_dec;
  logic        w_load_use;
  logic        w_advance;
  logic        w_accept;

  logic        r_valid;
  ex_bundle_t  r_ex;

  assign w_opcode   = i_if_inst[6:0];
  assign w_rd       = i_if_inst[11:7];
  assign w_funct3   = i_if_inst[14:12];
  assign o_rs1_addr = i_if_inst[19:15];
  assign o_rs2_addr = i_if_inst[24:20];

  imm_gen u_imm_gen (
    .i_inst  (i_if_inst),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_u (w_imm_u)
  );

  assign w_rs1_val = fwd_operand(o_rs1_addr, i_rs1_data,
                                 i_fwd_mem_we, i_fwd_mem_rd, i_fwd_mem_data,
                                 i_fwd_wb_we, i_fwd_wb_rd, i_fwd_wb_data);
  assign w_rs2_val = fwd_operand(o_rs2_addr, i_rs2_data,
                                 i_fwd_mem_we, i_fwd_mem_rd, i_fwd_mem_data,
                                 i_fwd_wb_we, i_fwd_wb_rd, i_fwd_wb_data);

  // Decode the offered instruction into the execute bundle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_dec      = '0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_imm_type = IMM_NONE;
    case (w_opcode)
      OPC_OP: begin
        w_uses_rs1     = 1'b1;
        w_uses_rs2     = 1'b1;
        w_dec.alu_en   = 1'b1;
        w_dec.in_a     = w_rs1_val;
        w_dec.in_b     = w_rs2_val;
        w_dec.funct3   = w_funct3;
        w_dec.funct7   = i_if_inst[31:25];
        w_dec.rd       = w_rd;
        w_dec.we       = (w_rd != REG_ZERO);
      end
      OPC_OP_IMM: begin
        w_uses_rs1     = 1'b1;
        w_imm_type     = IMM_I;
        w_dec.alu_en   = 1'b1;
        w_dec.alu_imm  = 1'b1;
        w_dec.in_a     = w_rs1_val;
        w_dec.funct3   = w_funct3;
        // Only shifts carry a meaningful funct7; ADDI with imm[10] set must
        // not turn into a subtract.
        w_dec.funct7   = ((w_funct3 == 3'b001) || (w_funct3 == 3'b101))
                         ? i_if_inst[31:25] : 7'd0;
        w_dec.rd       = w_rd;
        w_dec.we       = (w_rd != REG_ZERO);
      end
      OPC_LUI: begin
        w_imm_type     = IMM_U;
        w_dec.rd       = w_rd;
        w_dec.we       = (w_rd != REG_ZERO);
      end
      OPC_AUIPC: begin
        w_imm_type     = IMM_U;
        w_dec.in_a     = i_if_pc;
        w_dec.rd       = w_rd;
        w_dec.we       = (w_rd != REG_ZERO);
      end
      OPC_LOAD: begin
        w_uses_rs1     = 1'b1;
        w_imm_type     = IMM_I;
        w_dec.in_a     = w_rs1_val;
        w_dec.funct3   = w_funct3;
        w_dec.load     = 1'b1;
        w_dec.rd       = w_rd;
        w_dec.we       = (w_rd != REG_ZERO);
      end
      OPC_STORE: begin
        w_uses_rs1       = 1'b1;
        w_uses_rs2       = 1'b1;
        w_imm_type       = IMM_S;
        w_dec.in_a       = w_rs1_val;
        w_dec.funct3     = w_funct3;
        w_dec.store      = 1'b1;
        w_dec.store_data = w_rs2_val;
      end
      default: begin
        w_dec.illegal  = 1'b1;
      end
    endcase
    case (w_imm_type)
      IMM_I:   w_dec.in_b = w_imm_i;
      IMM_S:   w_dec.in_b = w_imm_s;
      IMM_U:   w_dec.in_b = w_imm_u;
      default: ;
    endcase
  end

  // A load still sitting in the output register cannot forward its data yet.
  assign w_load_use = r_valid && r_ex.load && (r_ex.rd != REG_ZERO) &&
                      ((w_uses_rs1 && (o_rs1_addr == r_ex.rd)) ||
                       (w_uses_rs2 && (o_rs2_addr == r_ex.rd)));

  assign w_advance  = !r_valid || ex.i_ex_ready;
  assign w_accept   = i_if_valid && !w_load_use;
  assign o_if_ready = w_advance && !w_load_use && !i_flush && !i_rst;

  // Output register: reset/flush kill it, otherwise load or bubble on advance.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (i_rst) begin
      r_valid <= 1'b0;
      r_ex    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_valid <= w_accept;
      if (w_accept) r_ex <= w_dec;
    end
  end

  assign ex.o_ex_valid      = r_valid;
  assign ex.o_ex_in_a       = r_ex.in_a;
  assign ex.o_ex_in_b       = r_ex.in_b;
  assign ex.o_ex_funct3     = r_ex.funct3;
  assign ex.o_ex_funct7     = r_ex.funct7;
  assign ex.o_ex_alu_en     = r_ex.alu_en;
  assign ex.o_ex_alu_imm    = r_ex.alu_imm;
  assign ex.o_ex_rd         = r_ex.rd;
  assign ex.o_ex_we         = r_ex.we;
  assign ex.o_ex_load       = r_ex.load;
  assign ex.o_ex_store      = r_ex.store;
  assign ex.o_ex_store_data = r_ex.store_data;
  assign ex.o_ex_illegal    = r_ex.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue with hand-computed expected values.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_issue_if ex_if ();

  decode_issue dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_if_valid     (if_valid),
    .i_if_inst      (if_inst),
    .i_if_pc        (if_pc),
    .o_if_ready     (if_ready),
    .o_rs1_addr     (rs1_addr),
    .o_rs2_addr     (rs2_addr),
    .i_rs1_data     (rs1_data),
    .i_rs2_data     (rs2_data),
    .i_fwd_mem_we   (mem_we),
    .i_fwd_mem_rd   (mem_rd),
    .i_fwd_mem_data (mem_data),
    .i_fwd_wb_we    (wb_we),
    .i_fwd_wb_rd    (wb_rd),
    .i_fwd_wb_data  (wb_data),
    .ex             (ex_if.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
    #1;
  endtask

  task automatic set_fwd(input logic m_we, input logic [4:0] m_rd, input logic [31:0] m_data,
                         input logic w_we, input logic [4:0] w_rd, input logic [31:0] w_data);
    mem_we = m_we; mem_rd = m_rd; mem_data = m_data;
    wb_we  = w_we; wb_rd  = w_rd; wb_data  = w_data;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    if_valid = 1'b1; if_inst = 32'h0000_0033; if_pc = '0;
    rs1_data = '0; rs2_data = '0;
    set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    ex_if.i_ex_ready = 1'b1;

    // Reset state, with an instruction offered the whole time.
    tick(); tick();
    chk("rst_valid",    ex_if.o_ex_valid, 0);
    chk("rst_in_a",     ex_if.o_ex_in_a,  0);
    chk("rst_we",       ex_if.o_ex_we,    0);
    chk("rst_if_ready", if_ready,         0);
    rst = 1'b0;

    // ADDI x1,x0,-1
    offer(32'hFFF0_0093, 32'h0);
    chk("addi_if_ready", if_ready, 1);
    tick();
    chk("addi_valid",   ex_if.o_ex_valid,   1);
    chk("addi_in_a",    ex_if.o_ex_in_a,    32'h0);
    chk("addi_in_b",    ex_if.o_ex_in_b,    32'hFFFF_FFFF);
    chk("addi_alu_imm", ex_if.o_ex_alu_imm, 1);
    chk("addi_alu_en",  ex_if.o_ex_alu_en,  1);
    chk("addi_funct7",  ex_if.o_ex_funct7,  0);
    chk("addi_rd",      ex_if.o_ex_rd,      1);
    chk("addi_we",      ex_if.o_ex_we,      1);

    // SUB x3,x1,x2: memory-stage forward beats writeback for x1
    set_fwd(1'b1, 5'd1, 32'd10, 1'b1, 5'd1, 32'd99);
    rs1_data = 32'd55; rs2_data = 32'd4;
    offer(32'h4020_81B3, 32'h4);
    chk("sub_rs1_addr", rs1_addr, 1);
    chk("sub_rs2_addr", rs2_addr, 2);
    tick();
    chk("sub_in_a",   ex_if.o_ex_in_a,   32'd10);
    chk("sub_in_b",   ex_if.o_ex_in_b,   32'd4);
    chk("sub_funct7", ex_if.o_ex_funct7, 32'h20);
    chk("sub_rd",     ex_if.o_ex_rd,     3);

    // ADD x4,x1,x2: writeback forward on x2, register file for x1
    set_fwd(1'b0, 5'd1, 32'd10, 1'b1, 5'd2, 32'd77);
    offer(32'h0020_8233, 32'h8);
    tick();
    chk("add_wb_in_a", ex_if.o_ex_in_a, 32'd55);
    chk("add_wb_in_b", ex_if.o_ex_in_b, 32'd77);

    // ADD x8,x0,x0: x0 reads zero even with forwards claiming x0
    set_fwd(1'b1, 5'd0, 32'd123, 1'b1, 5'd0, 32'd456);
    offer(32'h0000_0433, 32'hC);
    tick();
    chk("x0_in_a", ex_if.o_ex_in_a, 0);
    chk("x0_in_b", ex_if.o_ex_in_b, 0);
    set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // SRAI x10,x1,3 keeps funct7; ADDI x11,x0,0x400 must not
    offer(32'h4030_D513, 32'h10);
    tick();
    chk("srai_funct7", ex_if.o_ex_funct7, 32'h20);
    chk("srai_in_b",   ex_if.o_ex_in_b,   32'h403);
    offer(32'h4000_0593, 32'h14);
    tick();
    chk("addi400_funct7", ex_if.o_ex_funct7, 0);
    chk("addi400_in_b",   ex_if.o_ex_in_b,   32'h400);

    // SW x2,8(x1)
    rs1_data = 32'h2000; rs2_data = 32'hDEAD;
    offer(32'h0020_A423, 32'h18);
    tick();
    chk("sw_in_a",   ex_if.o_ex_in_a,       32'h2000);
    chk("sw_in_b",   ex_if.o_ex_in_b,       32'd8);
    chk("sw_store",  ex_if.o_ex_store,      1);
    chk("sw_we",     ex_if.o_ex_we,         0);
    chk("sw_sdata",  ex_if.o_ex_store_data, 32'hDEAD);

    // Unknown opcode
    offer(32'hFFFF_FFFF, 32'h1C);
    tick();
    chk("ill_valid",   ex_if.o_ex_valid,   1);
    chk("ill_flag",    ex_if.o_ex_illegal, 1);
    chk("ill_we",      ex_if.o_ex_we,      0);
    chk("ill_alu_en",  ex_if.o_ex_alu_en,  0);

    // LW x5,0(x2) then ADD x6,x5,x5: one bubble
    rs1_data = 32'h1000; rs2_data = 32'h0;
    offer(32'h0001_2283, 32'h20);
    tick();
    chk("lw_load", ex_if.o_ex_load, 1);
    chk("lw_rd",   ex_if.o_ex_rd,   5);
    chk("lw_in_a", ex_if.o_ex_in_a, 32'h1000);
    rs1_data = 32'h11; rs2_data = 32'h11;
    offer(32'h0052_8333, 32'h24);
    chk("lu_if_ready", if_ready, 0);
    tick();
    chk("lu_bubble", ex_if.o_ex_valid, 0);
    set_fwd(1'b1, 5'd5, 32'h42, 1'b0, 5'd0, '0);
    #1;
    chk("lu_if_ready_after", if_ready, 1);
    tick();
    chk("lu_add_valid", ex_if.o_ex_valid, 1);
    chk("lu_add_in_a",  ex_if.o_ex_in_a,  32'h42);
    chk("lu_add_rd",    ex_if.o_ex_rd,    6);
    set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // LUI x7,0x12345 at pc 0x100, then AUIPC x9 held for three stalled cycles
    offer(32'h1234_53B7, 32'h100);
    tick();
    chk("lui_in_a", ex_if.o_ex_in_a, 0);
    chk("lui_in_b", ex_if.o_ex_in_b, 32'h1234_5000);
    chk("lui_rd",   ex_if.o_ex_rd,   7);
    ex_if.i_ex_ready = 1'b0;
    offer(32'hABCD_E497, 32'h104);
    chk("stall_if_ready", if_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid",    ex_if.o_ex_valid, 1);
      chk("stall_in_b",     ex_if.o_ex_in_b,  32'h1234_5000);
      chk("stall_rd",       ex_if.o_ex_rd,    7);
      chk("stall_if_ready", if_ready,         0);
    end
    ex_if.i_ex_ready = 1'b1;
    #1;
    chk("release_if_ready", if_ready, 1);
    tick();
    chk("auipc_in_a", ex_if.o_ex_in_a, 32'h104);
    chk("auipc_in_b", ex_if.o_ex_in_b, 32'hABCD_E000);
    chk("auipc_we",   ex_if.o_ex_we,   1);

    // Flush while execute is stalled still kills the held instruction
    ex_if.i_ex_ready = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_held_valid", ex_if.o_ex_valid, 0);
    flush = 1'b0;
    ex_if.i_ex_ready = 1'b1;

    // Flush during a load-use stall: the stalled ADD never issues
    rs1_data = 32'h1000;
    offer(32'h0001_2283, 32'h200);
    tick();
    chk("lw2_valid", ex_if.o_ex_valid, 1);
    offer(32'h0052_8333, 32'h204);
    flush = 1'b1;
    #1;
    chk("flush_if_ready", if_ready, 0);
    tick();
    chk("flush_lu_valid", ex_if.o_ex_valid, 0);
    flush = 1'b0;
    if_valid = 1'b0;
    tick();
    chk("flush_no_add", ex_if.o_ex_valid, 0);

    // Reset while an instruction is held: discarded, then clean restart
    offer(32'hFFF0_0093, 32'h300);
    tick();
    ex_if.i_ex_ready = 1'b0;
    offer(32'h0020_8233, 32'h304);
    tick();
    chk("held_rd", ex_if.o_ex_rd, 1);
    rst = 1'b1;
    tick();
    chk("rst2_valid",    ex_if.o_ex_valid, 0);
    chk("rst2_rd",       ex_if.o_ex_rd,    0);
    chk("rst2_if_ready", if_ready,         0);
    rst = 1'b0;
    ex_if.i_ex_ready = 1'b1;
    offer(32'h4020_81B3, 32'h308);
    chk("post_rst_if_ready", if_ready, 1);
    tick();
    chk("post_rst_valid", ex_if.o_ex_valid, 1);
    chk("post_rst_rd",    ex_if.o_ex_rd,    3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
